// File: rtl/fpu_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : fpu_result_stage
// Brief    : fALU result stage - fcc update, NaN sticky, 2-entry writeback FIFO
// Revision : 1.0
// ============================================================================
module fpu_result_stage #(
    parameter int DEPTH = 2,
    parameter int REGW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [63:0]     in_out,
    input  logic            in_con,
    input  logic [3:0]      in_control,
    input  logic [REGW-1:0] in_dest,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [63:0]     wb_data,
    output logic [REGW-1:0] wb_dest,
    output logic            wb_double,
    output logic            fcc,
    output logic            nan_sticky,
    input  logic            clr_sticky
);

    localparam logic [1:0] c_CNT_FULL = DEPTH[1:0];

    logic [63:0]     r_data [0:1];
    logic [REGW-1:0] r_dest [0:1];
    logic            r_dbl  [0:1];
    logic            r_wptr;
    logic            r_rptr;
    logic [1:0]      r_count;
    logic            r_fcc;
    logic            r_nan;

    logic            w_is_cmp;
    logic            w_is_dbl;
    logic            w_accept;
    logic            w_push;
    logic            w_pop;
    logic [63:0]     w_push_data;
    logic            w_snan;
    logic            w_dnan;
    logic            w_nan_set;

    assign w_is_cmp    = (in_control[1:0] != 2'b00);
    assign w_is_dbl    = in_control[2];
    assign in_ready    = (r_count != c_CNT_FULL);
    // Illegal codes (bit 3 set) are consumed but have no side effects.
    assign w_accept    = in_valid & in_ready & ~in_control[3];
    assign w_push      = w_accept & ~w_is_cmp;
    assign wb_valid    = (r_count != 2'd0);
    assign w_pop       = wb_valid & wb_ready;
    assign w_push_data = w_is_dbl ? in_out : {in_out[63:32], 32'h0};

    assign w_snan    = (in_out[62:55] == 8'hFF)  && (in_out[54:32] != 23'h0);
    assign w_dnan    = (in_out[62:52] == 11'h7FF) && (in_out[51:0] != 52'h0);
    assign w_nan_set = w_push & (w_is_dbl ? w_dnan : w_snan);

    assign wb_data    = r_data[r_rptr];
    assign wb_dest    = r_dest[r_rptr];
    assign wb_double  = r_dbl[r_rptr];
    assign fcc        = r_fcc;
    assign nan_sticky = r_nan;

    // Payload storage needs no reset; validity is carried by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data[r_wptr] <= w_push_data;
            r_dest[r_wptr] <= in_dest;
            r_dbl[r_wptr]  <= w_is_dbl;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
            r_fcc   <= 1'b0;
            r_nan   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            if (w_accept && w_is_cmp) begin
                r_fcc <= in_con;
            end
            // A NaN detected in the same cycle as a clear takes priority.
            if (w_nan_set) begin
                r_nan <= 1'b1;
            end else if (clr_sticky) begin
                r_nan <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
